// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch stage bundle: imem request/response, decode stream, redirect
interface fetch_unit_if #(
    parameter int XLEN = 32
) ();
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            dec_valid;
    logic            dec_ready;
    logic [31:0]     dec_inst;
    logic [XLEN-1:0] dec_pc;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output imem_req_valid, imem_req_addr, dec_valid, dec_inst, dec_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, dec_ready,
               redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, dec_valid, dec_inst, dec_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, dec_ready,
               redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC owner, imem requester and prefetch FIFO; optional FETCH_JAL_PREDICT_EN
module fetch_unit #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = {XLEN{1'b0}},
    parameter int              FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_V = (CW + 1)'(FIFO_DEPTH);

    logic [XLEN-1:0] pc;
    logic [31:0]     fifo_inst [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_pc   [FIFO_DEPTH];
    logic [AW-1:0]   f_rd, f_wr;
    logic [CW-1:0]   f_cnt;
    logic [XLEN-1:0] pcq [FIFO_DEPTH];
    logic [AW-1:0]   q_rd, q_wr;
    logic [CW-1:0]   outstanding, drop_cnt;
    logic            skip_issue;

    logic            req_fire, rsp_keep, dec_fire, jal_hit;
    logic [XLEN-1:0] rsp_pc, pc_next;
    logic [CW-1:0]   outst_next, drop_next;

    // Slots in flight or buffered bound issue, so a response can never find the FIFO full
    assign bus.imem_req_valid = !rst && !bus.redirect_valid && !skip_issue &&
                                (({1'b0, f_cnt} + {1'b0, outstanding}) < DEPTH_V);
    assign bus.imem_req_addr  = pc;
    assign bus.dec_valid      = (f_cnt != '0);
    assign bus.dec_inst       = bus.dec_valid ? fifo_inst[f_rd] : 32'h0;
    assign bus.dec_pc         = bus.dec_valid ? fifo_pc[f_rd]   : {XLEN{1'b0}};

    assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
    assign dec_fire = bus.dec_valid && bus.dec_ready;
    assign rsp_pc   = pcq[q_rd];
    assign rsp_keep = bus.imem_rsp_valid && !bus.redirect_valid && (drop_cnt == '0);

`ifdef FETCH_JAL_PREDICT_EN
    logic [XLEN-1:0] jal_imm;
    assign jal_hit = rsp_keep && (bus.imem_rsp_data[6:0] == 7'b1101111);
    assign jal_imm = {{(XLEN-21){bus.imem_rsp_data[31]}}, bus.imem_rsp_data[31],
                      bus.imem_rsp_data[19:12], bus.imem_rsp_data[20],
                      bus.imem_rsp_data[30:21], 1'b0};

    // A taken JAL blocks the issue slot right after it so the new PC is fetched cleanly
    always_ff @(posedge clk) begin
        if (rst) skip_issue <= 1'b0;
        else     skip_issue <= jal_hit;
    end
`else
    assign jal_hit    = 1'b0;
    assign skip_issue = 1'b0;
`endif

    // Next PC and drop count: external redirect beats JAL, which beats sequential advance
    always_comb begin
        outst_next = outstanding + CW'(req_fire) - CW'(bus.imem_rsp_valid);
        pc_next    = pc;
        drop_next  = drop_cnt;
        if (req_fire) pc_next = pc + XLEN'(4);
        if (bus.imem_rsp_valid && (drop_cnt != '0)) drop_next = drop_cnt - CW'(1);
`ifdef FETCH_JAL_PREDICT_EN
        if (jal_hit) begin
            pc_next   = rsp_pc + jal_imm;
            drop_next = outst_next;
        end
`endif
        if (bus.redirect_valid) begin
            pc_next   = bus.redirect_pc & ~XLEN'(3);
            drop_next = outst_next;
        end
    end

    // Control state: PC, FIFO/queue pointers and counts
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            f_rd        <= '0;
            f_wr        <= '0;
            f_cnt       <= '0;
            q_rd        <= '0;
            q_wr        <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            pc          <= pc_next;
            outstanding <= outst_next;
            drop_cnt    <= drop_next;
            if (req_fire)           q_wr <= q_wr + AW'(1);
            if (bus.imem_rsp_valid) q_rd <= q_rd + AW'(1);
            if (bus.redirect_valid) begin
                f_rd  <= f_wr;
                f_cnt <= '0;
            end else begin
                if (rsp_keep) f_wr <= f_wr + AW'(1);
                if (dec_fire) f_rd <= f_rd + AW'(1);
                f_cnt <= f_cnt + CW'(rsp_keep) - CW'(dec_fire);
            end
        end
    end

    // Storage arrays: empty slots are never observed, so they carry no reset
    always_ff @(posedge clk) begin
        if (req_fire) pcq[q_wr] <= pc;
        if (rsp_keep) begin
            fifo_inst[f_wr] <= bus.imem_rsp_data;
            fifo_pc[f_wr]   <= rsp_pc;
        end
    end
endmodule
